// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/flow controller and the IFU.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_DROP      = 2'd1,
        ST_HALT_WAIT = 2'd2,
        ST_HALTED    = 2'd3
    } ctrl_state_t;

    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use comparator: a consumer reading a register that a load in the
// producer stage has not yet returned.
module hazard_detect #(
    parameter int REG_IDX_W = 5
) (
    input  logic                 cons_valid,
    input  logic [REG_IDX_W-1:0] cons_rs1,
    input  logic [REG_IDX_W-1:0] cons_rs2,
    input  logic                 cons_use_rs1,
    input  logic                 cons_use_rs2,
    input  logic                 prod_valid,
    input  logic                 prod_is_load,
    input  logic [REG_IDX_W-1:0] prod_rd,
    output logic                 hazard
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = cons_use_rs1 && (cons_rs1 == prod_rd);
    assign rs2_hit = cons_use_rs2 && (cons_rs2 == prod_rd);

    // x0 is never written, so a load targeting it cannot create a dependency.
    assign hazard = cons_valid && prod_valid && prod_is_load &&
                    (prod_rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Central hazard and flow controller for the 5-stage in-order pipeline:
// load-use stalls, redirect flushes, stale-fetch dropping and ebreak halt.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int ADDR_W    = 64,
    parameter int REG_IDX_W = 5,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_use_rs1,
    input  logic                 id_use_rs2,
    input  logic                 ex_valid,
    input  logic                 ex_is_load,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 ex_br_taken,
    input  logic [ADDR_W-1:0]    ex_br_target,
    input  logic                 mem_valid,
    input  logic                 wb_valid,
    input  logic                 wb_trap,
    input  logic [ADDR_W-1:0]    wb_trap_target,
    input  logic                 wb_ebreak,
    input  logic                 if_busy,
    input  logic                 if_resp_valid,
    output logic                 stall_id,
    output logic                 flush_id,
    output logic                 flush_ex,
    output logic                 flush_mem,
    output logic                 redirect_valid,
    output logic [ADDR_W-1:0]    redirect_pc,
    output logic                 drop_fetch,
    output logic                 fetch_en,
    output logic                 halted,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);

    ctrl_state_t state;
    ctrl_state_t state_nxt;

    logic hazard;
    logic live;
    logic ebreak_hit;
    logic trap_hit;
    logic br_hit;
    logic redirect;
    logic drained;

    hazard_detect #(
        .REG_IDX_W(REG_IDX_W)
    ) u_hazard_detect (
        .cons_valid  (id_valid),
        .cons_rs1    (id_rs1),
        .cons_rs2    (id_rs2),
        .cons_use_rs1(id_use_rs1),
        .cons_use_rs2(id_use_rs2),
        .prod_valid  (ex_valid),
        .prod_is_load(ex_is_load),
        .prod_rd     (ex_rd),
        .hazard      (hazard)
    );

    // Redirects and ebreak only act while the pipeline is still executing;
    // once halting starts every younger instruction is already flushed.
    assign live       = (state == ST_RUN) || (state == ST_DROP);
    assign ebreak_hit = live && wb_valid && wb_ebreak;
    assign trap_hit   = live && !ebreak_hit && wb_trap;
    assign br_hit     = live && !ebreak_hit && !wb_trap && ex_br_taken;
    assign redirect   = trap_hit || br_hit;
    assign drained    = !id_valid && !ex_valid && !mem_valid && !if_busy;

    assign stall_id       = (state == ST_RUN) && hazard && !redirect;
    assign flush_id       = ebreak_hit || redirect;
    assign flush_ex       = ebreak_hit || trap_hit || stall_id;
    assign flush_mem      = ebreak_hit || trap_hit;
    assign redirect_valid = redirect;
    assign redirect_pc    = trap_hit ? wb_trap_target :
                            br_hit   ? ex_br_target   : '0;

    always_comb begin
        state_nxt  = state;
        fetch_en   = 1'b0;
        drop_fetch = 1'b0;
        halted     = 1'b0;
        case (state)
            ST_RUN: begin
                fetch_en = !ebreak_hit;
                if (ebreak_hit)
                    state_nxt = ST_HALT_WAIT;
                else if (redirect && if_busy && !if_resp_valid)
                    state_nxt = ST_DROP;
            end
            ST_DROP: begin
                fetch_en   = !ebreak_hit;
                drop_fetch = if_resp_valid;
                if (ebreak_hit)
                    state_nxt = ST_HALT_WAIT;
                else if (if_resp_valid)
                    state_nxt = ST_RUN;
            end
            ST_HALT_WAIT: begin
                drop_fetch = if_resp_valid;
                if (drained)
                    state_nxt = ST_HALTED;
            end
            ST_HALTED: begin
                halted = 1'b1;
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RUN;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (stall_id)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (redirect_valid)
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized and directed bench for pipe_ctrl against a flag-based reference model.
module tb_pipe_ctrl;

    localparam int ADDR_W    = 64;
    localparam int REG_IDX_W = 5;
    localparam int CNT_W     = 32;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 id_valid, id_use_rs1, id_use_rs2;
    logic [REG_IDX_W-1:0] id_rs1, id_rs2, ex_rd;
    logic                 ex_valid, ex_is_load, ex_br_taken;
    logic [ADDR_W-1:0]    ex_br_target, wb_trap_target;
    logic                 mem_valid, wb_valid, wb_trap, wb_ebreak;
    logic                 if_busy, if_resp_valid;
    logic                 stall_id, flush_id, flush_ex, flush_mem;
    logic                 redirect_valid, drop_fetch, fetch_en, halted;
    logic [ADDR_W-1:0]    redirect_pc;
    logic [CNT_W-1:0]     stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    pipe_ctrl #(
        .ADDR_W   (ADDR_W),
        .REG_IDX_W(REG_IDX_W),
        .CNT_W    (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .id_valid      (id_valid),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_use_rs1    (id_use_rs1),
        .id_use_rs2    (id_use_rs2),
        .ex_valid      (ex_valid),
        .ex_is_load    (ex_is_load),
        .ex_rd         (ex_rd),
        .ex_br_taken   (ex_br_taken),
        .ex_br_target  (ex_br_target),
        .mem_valid     (mem_valid),
        .wb_valid      (wb_valid),
        .wb_trap       (wb_trap),
        .wb_trap_target(wb_trap_target),
        .wb_ebreak     (wb_ebreak),
        .if_busy       (if_busy),
        .if_resp_valid (if_resp_valid),
        .stall_id      (stall_id),
        .flush_id      (flush_id),
        .flush_ex      (flush_ex),
        .flush_mem     (flush_mem),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .drop_fetch    (drop_fetch),
        .fetch_en      (fetch_en),
        .halted        (halted),
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt)
    );

    int total = 0;
    int bad   = 0;

    // Reference: halted / draining-for-halt / owes-one-drop flags plus counters.
    bit          m_halted;
    bit          m_halting;
    bit          m_drop;
    logic [31:0] m_stall;
    logic [31:0] m_flush;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        rst = 1'b0; id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_valid = 1'b0; ex_is_load = 1'b0;
        ex_rd = '0; ex_br_taken = 1'b0; ex_br_target = '0; mem_valid = 1'b0;
        wb_valid = 1'b0; wb_trap = 1'b0; wb_trap_target = '0; wb_ebreak = 1'b0;
        if_busy = 1'b0; if_resp_valid = 1'b0;
    endtask

    task automatic model_clear();
        m_halted = 0; m_halting = 0; m_drop = 0; m_stall = '0; m_flush = '0;
    endtask

    // Checks every output mid-cycle, then advances the model across the edge.
    task automatic step();
        bit live, ebk, trap, br, redir, dep, stall, resp_drop;
        logic [63:0] rpc;
        @(negedge clk);
        live  = !m_halted && !m_halting;
        ebk   = live && wb_valid && wb_ebreak;
        trap  = live && !ebk && wb_trap;
        br    = live && !ebk && !wb_trap && ex_br_taken;
        redir = trap || br;
        dep   = (id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd);
        stall = live && !m_drop && id_valid && ex_valid && ex_is_load &&
                ex_rd != 0 && dep && !redir;
        rpc   = trap ? wb_trap_target : (br ? ex_br_target : 64'd0);
        resp_drop = if_resp_valid && ((live && m_drop) || m_halting);
        check("stall_id",  stall_id, stall);
        check("flush_id",  flush_id, ebk || redir);
        check("flush_ex",  flush_ex, ebk || trap || stall);
        check("flush_mem", flush_mem, ebk || trap);
        check("redir_v",   redirect_valid, redir);
        check("redir_pc",  redirect_pc, rpc);
        check("drop",      drop_fetch, resp_drop);
        check("fetch_en",  fetch_en, live && !ebk);
        check("halted",    halted, m_halted);
        check("stall_cnt", stall_cnt, m_stall);
        check("flush_cnt", flush_cnt, m_flush);
        @(posedge clk);
        if (rst) begin
            model_clear();
        end else begin
            m_stall = m_stall + 32'(stall);
            m_flush = m_flush + 32'(redir);
            if (m_halting) begin
                if (!id_valid && !ex_valid && !mem_valid && !if_busy) begin
                    m_halting = 0;
                    m_halted  = 1;
                end
            end else if (ebk) begin
                m_halting = 1;
                m_drop    = 0;
            end else if (live) begin
                if (m_drop) m_drop = !if_resp_valid;
                else        m_drop = redir && if_busy && !if_resp_valid;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        step();

        // Load-use on rs1, then the same pair with ex_rd = x0.
        ex_valid = 1; ex_is_load = 1; ex_rd = 5;
        id_valid = 1; id_use_rs1 = 1; id_rs1 = 5; id_rs2 = 1; id_use_rs2 = 1;
        step();
        idle_inputs();
        step();
        check("p1_stall_cnt", stall_cnt, 32'd1);
        ex_valid = 1; ex_is_load = 1; ex_rd = 0;
        id_valid = 1; id_use_rs1 = 1; id_rs1 = 0;
        step();
        idle_inputs();

        // Branch with no fetch outstanding.
        ex_valid = 1; ex_br_taken = 1; ex_br_target = 64'h8000_0100;
        step();
        idle_inputs();
        step();
        check("p2_flush_cnt", flush_cnt, 32'd1);

        // Trap and branch together: trap wins, one redirect counted.
        wb_valid = 1; wb_trap = 1; wb_trap_target = 64'h8000_0004;
        ex_valid = 1; ex_br_taken = 1; ex_br_target = 64'h8000_0100;
        step();
        idle_inputs();
        step();
        check("p3_flush_cnt", flush_cnt, 32'd2);

        // Redirect with fetch in flight; response three cycles later is dropped.
        ex_valid = 1; ex_br_taken = 1; ex_br_target = 64'h8000_0200; if_busy = 1;
        step();
        idle_inputs(); if_busy = 1;
        step(); step();
        if_resp_valid = 1;
        step();
        idle_inputs();
        step();

        // Ebreak drain with MEM and IFU still busy, then stay halted.
        wb_valid = 1; wb_ebreak = 1; mem_valid = 1; if_busy = 1;
        step();
        idle_inputs(); mem_valid = 1; if_busy = 1;
        step(); step();
        idle_inputs();
        step();
        repeat (20) step();
        check("p5_halted", halted, 1'b1);

        // Reset out of HALTED, then out of DROP.
        do_reset();
        step();
        ex_valid = 1; ex_br_taken = 1; ex_br_target = 64'h8000_0300; if_busy = 1;
        step();
        idle_inputs(); if_busy = 1;
        do_reset();
        idle_inputs(); if_resp_valid = 1;
        step();
        idle_inputs();

        for (int i = 0; i < 4000; i++) begin
            rst            = ($urandom_range(0, 299) == 0) || (m_halted && $urandom_range(0, 7) == 0);
            id_valid       = $urandom_range(0, 3) != 0;
            id_rs1         = REG_IDX_W'($urandom_range(0, 3));
            id_rs2         = REG_IDX_W'($urandom_range(0, 3));
            id_use_rs1     = $urandom_range(0, 1) == 1;
            id_use_rs2     = $urandom_range(0, 1) == 1;
            ex_valid       = $urandom_range(0, 3) != 0;
            ex_is_load     = $urandom_range(0, 1) == 1;
            ex_rd          = REG_IDX_W'($urandom_range(0, 3));
            ex_br_taken    = $urandom_range(0, 4) == 0;
            ex_br_target   = {$urandom, $urandom};
            mem_valid      = $urandom_range(0, 2) == 0;
            wb_valid       = $urandom_range(0, 3) != 0;
            wb_trap        = $urandom_range(0, 7) == 0;
            wb_trap_target = {$urandom, $urandom};
            wb_ebreak      = $urandom_range(0, 39) == 0;
            if_busy        = $urandom_range(0, 1) == 1;
            if_resp_valid  = $urandom_range(0, 2) == 0;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central hazard and flow controller for the 5-stage in-order pipeline (IF/ID/EX/MEM/WB).
- Generates load-use stalls for the ID stage.
- Generates stage flushes and the PC redirect for branch and trap events.
- Discards the response of a fetch that was in flight when a redirect occurred.
- Sequences the ebreak halt: drain the pipeline, then stop.
- Sits beside the stage registers and drives their flush/ready qualifiers and the IFU redirect port.

Parameters:
ADDR_W, 64, PC/target width
REG_IDX_W, 5, architectural register index width
CNT_W, 32, width of the stall and flush performance counters

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
id_valid  in  1  ID stage holds a valid instruction
id_rs1  in  REG_IDX_W  ID source register 1 index
id_rs2  in  REG_IDX_W  ID source register 2 index
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
ex_valid  in  1  EX stage valid
ex_is_load  in  1  EX instruction is a load
ex_rd  in  REG_IDX_W  EX destination register index
ex_br_taken  in  1  EX resolved a taken branch or jump
ex_br_target  in  ADDR_W  branch/jump target
mem_valid  in  1  MEM stage valid
wb_valid  in  1  WB stage valid
wb_trap  in  1  WB instruction raises a trap or performs mret/ecall
wb_trap_target  in  ADDR_W  trap/return target PC
wb_ebreak  in  1  WB instruction is ebreak
if_busy  in  1  IFU has an outstanding fetch request
if_resp_valid  in  1  IFU fetch response returns this cycle
stall_id  out  1  hold ID (deasserts id_ready_go)
flush_id  out  1  invalidate the IF/ID register
flush_ex  out  1  invalidate the ID/EX register
flush_mem  out  1  invalidate the EX/MEM register
redirect_valid  out  1  load redirect_pc into the IFU PC
redirect_pc  out  ADDR_W  new fetch PC
drop_fetch  out  1  discard the current IFU response
fetch_en  out  1  IFU may issue new requests
halted  out  1  core halted by ebreak (sticky)
stall_cnt  out  CNT_W  cycles with stall_id asserted
flush_cnt  out  CNT_W  number of redirect events

Behaviour:
Reset values: state=RUN, fetch_en=1, halted=0, counters=0. All other outputs are 0 whenever their conditions are false.

Load-use stall (combinational):
- stall_id = state==RUN & id_valid & ex_valid & ex_is_load & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- While stalled, flush_ex=1 inserts a bubble into EX.
- Suppressed if any redirect fires in the same cycle.

Redirect priority (combinational, same-cycle):
- Priority is wb_trap > ex_br_taken.
- Trap: flush_id=flush_ex=flush_mem=1, redirect_pc=wb_trap_target.
- Branch: flush_id=1, redirect_pc=ex_br_target. flush_ex=0, because the EX instruction itself is older and must not be flushed.
- redirect_valid=1 in the same cycle as the flushes. flush_cnt increments by 1 per redirect cycle.

FSM:
- RUN
  - wb_ebreak & wb_valid -> HALT_WAIT. Same cycle: flush_id=flush_ex=flush_mem=1, fetch_en=0. No redirect.
  - Redirect while (if_busy & !if_resp_valid) -> DROP.
- DROP
  - drop_fetch = if_resp_valid.
  - if_resp_valid -> RUN, with the response dropped.
  - A new redirect while in DROP: honour it (new redirect_valid/flushes), stay in DROP. Only one outstanding fetch exists, so one drop suffices.
  - Ebreak in DROP -> HALT_WAIT; the drop obligation moves to HALT_WAIT.
- HALT_WAIT
  - fetch_en=0. drop_fetch=if_resp_valid.
  - Exit to HALTED when !id_valid & !ex_valid & !mem_valid & !if_busy.
  - wb_trap and ex_br_taken are ignored here: younger instructions are already flushed.
- HALTED
  - fetch_en=0, halted=1, all other control outputs 0.
  - Left only by rst.

Counters: stall_cnt increments on every stall_id cycle. Both counters wrap modulo 2^CNT_W with no saturation.

Reset mid-operation: rst has priority over everything. It returns state=RUN, clears halted and the counters, and any pending drop is forgotten. The IFU is reset by the same rst.

Decomposition:
- Shared package: FSM state encoding (RUN, DROP, HALT_WAIT, HALTED, 2 bits) and the reset-PC constant used by the IFU.
- Sub-module hazard_detect: the combinational load-use comparator, reusable later for MEM-stage load hazards.
- Counters use the existing Reg primitive with wen.

Test Plan:
1. Load-use: EX `ld x5` valid, ID `add x6,x5,x1` (use_rs1, rs1=5) -> stall_id=1 and flush_ex=1 for 1 cycle; stall_cnt=1. With ex_rd=0 -> no stall.
2. Branch: ex_br_taken=1, target=0x80000100, if_busy=0 -> same cycle redirect_valid=1, redirect_pc=0x80000100, flush_id=1, flush_ex=0; flush_cnt=1; FSM stays RUN.
3. Trap vs branch simultaneous: wb_trap target 0x80000004 and ex_br_taken target 0x80000100 -> redirect_pc=0x80000004, flush_id/ex/mem=1, flush_cnt increments by 1 only.
4. Redirect with fetch outstanding: if_busy=1, resp 3 cycles later -> DROP; drop_fetch=1 exactly on the if_resp_valid cycle; next cycle RUN with drop_fetch=0.
5. Ebreak drain: wb_ebreak with mem_valid=1 for 2 further cycles and if_busy=1 -> fetch_en=0 immediately; halted=1 the cycle after all valids and if_busy clear; stays halted for 20 cycles.
6. Reset while HALTED and while in DROP -> next cycle state RUN, halted=0, fetch_en=1, counters=0.
